// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gate instruction issue,
// and the writeback port updates the register file. Optional feature: SB_BYPASS_EN.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [15:0]       iss_req,
    input  logic [15:0]       iss_prov,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [3:0]        wb_reg,
    input  logic [63:0]       wb_data,
    input  logic              flush,
    output logic [15:0][63:0] regx,
    output logic [15:0]       busy,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];
    logic [15:0]      wb_hit;
    logic [15:0]      sat;
    logic [15:0]      busy_eff;
    logic             accept;
    logic             underflow;

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            busy[n]   = (cnt_q[n] != '0);
            wb_hit[n] = wb_valid && (wb_reg == 4'(n));
            sat[n]    = (cnt_q[n] == CntMax);
`ifdef SB_BYPASS_EN
            // A source whose last pending write lands this cycle is forwarded from wb_data.
            busy_eff[n] = busy[n] && !(wb_hit[n] && (cnt_q[n] == CntOne));
`else
            busy_eff[n] = busy[n];
`endif
        end
        iss_ready = !flush && ((iss_req & busy_eff) == '0) && ((iss_prov & sat) == '0);
        accept    = iss_valid && iss_ready;
    end

    always_comb begin
        underflow = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cnt_d[n] = cnt_q[n];
            if (accept && iss_prov[n] && wb_hit[n]) begin
                cnt_d[n] = cnt_q[n];
            end else if (accept && iss_prov[n]) begin
                cnt_d[n] = cnt_q[n] + CntOne;
            end else if (wb_hit[n]) begin
                if (cnt_q[n] != '0) cnt_d[n] = cnt_q[n] - CntOne;
                else                underflow = 1'b1;
            end
            if (flush) cnt_d[n] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < 16; n++) cnt_q[n] <= '0;
            regx   <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int n = 0; n < 16; n++) cnt_q[n] <= cnt_d[n];
            if (wb_valid)  regx[wb_reg] <= wb_data;
            if (underflow) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios then random traffic
// against a counter-per-register reference model.
module tb_reg_scoreboard;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              iss_valid;
    logic [15:0]       iss_req;
    logic [15:0]       iss_prov;
    logic              iss_ready;
    logic              wb_valid;
    logic [3:0]        wb_reg;
    logic [63:0]       wb_data;
    logic              flush;
    logic [15:0][63:0] regx;
    logic [15:0]       busy;
    logic              sb_err;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid), .iss_req(iss_req),
        .iss_prov(iss_prov), .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .regx(regx), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          mcnt [16];
    logic [63:0] mreg [16];
    bit          merr;
    logic        last_ready;

`ifdef SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input logic [15:0] rq, input logic [15:0] pv,
                                       input bit wv, input logic [3:0] wr, input bit fl);
        if (fl) return 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (rq[n] && mcnt[n] > 0 &&
                !(BYPASS && wv && int'(wr) == n && mcnt[n] == 1)) return 1'b0;
            if (pv[n] && mcnt[n] == SAT) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit rn, input bit v, input logic [15:0] rq, input logic [15:0] pv,
                        input bit wv, input logic [3:0] wr, input logic [63:0] wd,
                        input bit fl);
        bit                acc;
        bit                er;
        logic [15:0]       exp_busy;
        logic [15:0][63:0] exp_regx;
        @(negedge clk);
        reset_n = rn; iss_valid = v; iss_req = rq; iss_prov = pv;
        wb_valid = wv; wb_reg = wr; wb_data = wd; flush = fl;
        #1;
        acc = v && model_ready(rq, pv, wv, wr, fl);
        last_ready = iss_ready;
        if (rn) chk("iss_ready", 1024'(iss_ready), 1024'(model_ready(rq, pv, wv, wr, fl)));
        @(posedge clk);
        if (!rn) begin
            for (int n = 0; n < 16; n++) begin mcnt[n] = 0; mreg[n] = '0; end
            merr = 1'b0;
        end else begin
            for (int n = 0; n < 16; n++) begin
                er = wv && int'(wr) == n;
                if (acc && pv[n] && er) ;
                else if (acc && pv[n]) mcnt[n]++;
                else if (er && mcnt[n] > 0) mcnt[n]--;
                else if (er) merr = 1'b1;
                if (fl) mcnt[n] = 0;
            end
            if (wv) mreg[wr] = wd;
        end
        #1;
        for (int n = 0; n < 16; n++) begin
            exp_busy[n] = (mcnt[n] != 0);
            exp_regx[n] = mreg[n];
        end
        chk("busy", 1024'(busy), 1024'(exp_busy));
        chk("regx", 1024'(regx), 1024'(exp_regx));
        chk("sb_err", 1024'(sb_err), 1024'(merr));
    endtask

    task automatic idle();
        step(1, 0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        logic [15:0] rq, pv;
        reset_n = 0; iss_valid = 0; iss_req = '0; iss_prov = '0;
        wb_valid = 0; wb_reg = '0; wb_data = '0; flush = 0;
        do_reset();
        do_reset();
        chk("reset_busy", 1024'(busy), 1024'(16'h0000));
        chk("reset_err", 1024'(sb_err), 1024'(1'b0));

        // RAX dependency stall, then release by writeback
        step(1, 1, 16'h0000, 16'h0001, 0, '0, '0, 0);
        chk("r027_ready_after_reset", 1024'(last_ready), 1024'(1'b1));
        step(1, 1, 16'h0001, 16'h0000, 0, '0, '0, 0);
        chk("r030_stall", 1024'(last_ready), 1024'(1'b0));
        chk("r030_busy", 1024'(busy), 1024'(16'h0001));
        step(1, 1, 16'h0001, 16'h0000, 1, 4'd0, 64'h1122334455667788, 0);
        chk("r031_wb_cycle_ready", 1024'(last_ready), 1024'(BYPASS));
        step(1, 1, 16'h0001, 16'h0000, 0, '0, '0, 0);
        chk("r031_next_ready", 1024'(last_ready), 1024'(1'b1));
        chk("r031_regx0", 1024'(regx[0]), 1024'(64'h1122334455667788));

        // RBX saturation
        repeat (3) step(1, 1, 16'h0000, 16'h0008, 0, '0, '0, 0);
        step(1, 1, 16'h0000, 16'h0008, 0, '0, '0, 0);
        chk("r032_sat_stall", 1024'(last_ready), 1024'(1'b0));
        step(1, 1, 16'h0000, 16'h0008, 1, 4'd3, 64'hAA, 0);
        chk("r032_sat_wb_cycle", 1024'(last_ready), 1024'(1'b0));
        step(1, 1, 16'h0000, 16'h0008, 0, '0, '0, 0);
        chk("r032_after_wb", 1024'(last_ready), 1024'(1'b1));

        // Underflow is sticky until reset
        do_reset();
        step(1, 0, '0, '0, 1, 4'd5, 64'hDEADBEEF_CAFEF00D, 0);
        chk("r033_err", 1024'(sb_err), 1024'(1'b1));
        chk("r033_regx5", 1024'(regx[5]), 1024'(64'hDEADBEEF_CAFEF00D));
        step(1, 1, 16'h0000, 16'h0010, 1, 4'd4, 64'h5, 0);
        idle();
        chk("r033_sticky", 1024'(sb_err), 1024'(1'b1));
        do_reset();
        chk("r033_cleared", 1024'(sb_err), 1024'(1'b0));

        // Same-cycle accept and writeback to one register
        step(1, 1, 16'h0000, 16'h0004, 0, '0, '0, 0);
        step(1, 1, 16'h0000, 16'h0004, 1, 4'd2, 64'h22, 0);
        chk("r034_busy2", 1024'(busy[2]), 1024'(1'b1));
        chk("r034_err", 1024'(sb_err), 1024'(1'b0));
        step(1, 0, '0, '0, 1, 4'd2, 64'h23, 0);
        chk("r034_count_was_1", 1024'(busy[2]), 1024'(1'b0));

        // Flush with everything busy and a concurrent writeback
        step(1, 1, 16'h0000, 16'hFFFF, 0, '0, '0, 0);
        step(1, 1, 16'h0000, 16'h0000, 1, 4'd7, 64'h7777_0000_7777_0000, 1);
        chk("r035_flush_ready", 1024'(last_ready), 1024'(1'b0));
        chk("r035_busy", 1024'(busy), 1024'(16'h0000));
        chk("r035_regx7", 1024'(regx[7]), 1024'(64'h7777_0000_7777_0000));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rq = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'(1 << $urandom_range(0, 15));
            pv = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) do_reset();
            else step(1, 1'($urandom_range(0, 1)), rq, pv, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), {$urandom, $urandom},
                      $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: CNT_W, default 2, width of each per-register pending-write counter; saturation value is 2^CNT_W-1.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 iss_valid  input  1  operand-fetch stage presents an instruction this cycle.
REQ-005 iss_req  input  16  one-hot-or-zero mask of source registers the instruction reads (bit n = register n, RAX=0 .. R15=15).
REQ-006 iss_prov  input  16  mask of destination registers the instruction will write.
REQ-007 iss_ready  output  1  combinational; instruction may issue this cycle.
REQ-008 wb_valid  input  1  writeback of one result this cycle.
REQ-009 wb_reg  input  4  destination register index of the writeback.
REQ-010 wb_data  input  64  result value.
REQ-011 flush  input  1  discard all in-flight writes.
REQ-012 regx  output  16x64  registered architectural register file, drives the operand-fetch read port.
REQ-013 busy  output  16  bit n = 1 when counter n is non-zero (registered state, no bypass).
REQ-014 sb_err  output  1  sticky underflow flag.

Function
REQ-015 Accept = iss_valid && iss_ready; an iss_valid cycle with iss_ready=0 is a stall, no state change, the upstream holds its inputs.
REQ-016 iss_ready = 1 when (iss_req & busy_eff) == 0 and no register in iss_prov has a counter at saturation; busy_eff per Configuration.
REQ-017 On accept, counter n increments by 1 for every set bit n of iss_prov.
REQ-018 On wb_valid, regx[wb_reg] <= wb_data at the same edge, all 64 bits, no size masking.
REQ-019 On wb_valid with counter[wb_reg] > 0, counter[wb_reg] decrements by 1.
REQ-020 On wb_valid with counter[wb_reg] == 0: counter stays 0, regx is still written, sb_err sets to 1 and holds until reset.
REQ-021 Accept and wb_valid to the same register in one cycle: counter net unchanged; no underflow flagged even when the counter was 0.
REQ-022 Accept with iss_prov = 0 (e.g. destination absent) changes no counter; iss_req = 0 never stalls on busy.
REQ-023 flush: all counters 0 at the next edge, overriding accept and writeback counter updates in that cycle; a concurrent wb_valid still writes regx; iss_ready is forced 0 during flush.
REQ-024 iss_ready has no dependence on iss_valid, so there is no combinational loop with the upstream.
REQ-025 Latency: writeback data is visible on regx one cycle after wb_valid; busy clears in that same cycle.

Reset
REQ-026 With reset_n low at an edge: all counters 0, busy 0, regx all 0, sb_err 0; reset overrides flush, accept and writeback.
REQ-027 reset_n low mid-stall or with writes outstanding discards them; iss_ready is 1 in the first cycle after reset release.

Configuration
REQ-028 Macro SB_BYPASS_EN: when defined, busy_eff[n] = busy[n] and not (wb_valid && wb_reg == n && counter[n] == 1), so a source released by a same-cycle writeback does not stall; the operand-fetch stage takes wb_data for it.
REQ-029 Without SB_BYPASS_EN, busy_eff = busy, and a dependent instruction issues no earlier than the cycle after the writeback.

Verification
REQ-030 Reset, then issue prov=0x0001 (RAX), then issue req=0x0001 -> second cycle iss_ready=0, busy=0x0001.
REQ-031 From REQ-030 state, wb_valid with wb_reg=0, wb_data=0x1122334455667788 and req=0x0001 held -> with SB_BYPASS_EN iss_ready=1 in the wb cycle; without it, iss_ready=1 the next cycle; regx[0]=0x1122334455667788.
REQ-032 Three accepts with prov=0x0008 (RBX, CNT_W=2) -> counter=3; a fourth prov=0x0008 -> iss_ready=0 until one wb to reg 3.
REQ-033 wb_valid to reg 5 with counter 0 -> regx[5] updated, sb_err=1 and stays 1 across later traffic until reset_n=0.
REQ-034 Accept with prov=0x0004 and wb_valid wb_reg=2 in one cycle, counter 1 -> counter stays 1, busy[2]=1, sb_err=0.
REQ-035 flush with busy=0xFFFF and concurrent wb to reg 7 -> next cycle busy=0, regx[7]=wb_data, iss_ready=0 in the flush cycle.
